scope_cmd_ctrl: RTL and testbench
=================================

SCOPE_CMD_CTRL -- requirements
Module: scope_cmd_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, capture-buffer address width (DEPTH = 2**ADDR_W samples).
REQ-002 The block SHALL have port clk  input  1  system clock, the only clock.
REQ-003 The block SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-004 The block SHALL have port rx_data  input  8  byte from UART receiver.
REQ-005 The block SHALL have port rx_valid  input  1  one-cycle strobe, rx_data valid.
REQ-006 The block SHALL have port tx_data  output  8  byte to UART transmitter.
REQ-007 The block SHALL have port tx_valid  output  1  tx_data valid.
REQ-008 The block SHALL have port tx_ready  input  1  transmitter accepts byte.
REQ-009 The block SHALL have port probe  input  40  sampled signals.
REQ-010 The block SHALL have port mem_we  output  1  capture-buffer write enable.
REQ-011 The block SHALL have port mem_addr  output  ADDR_W  capture-buffer address.
REQ-012 The block SHALL have port mem_wdata  output  40  capture-buffer write data.
REQ-013 The block SHALL have port mem_rdata  input  40  read data, valid one cycle after mem_addr.
REQ-014 The block SHALL have port armed  output  1  high in ARMED.
REQ-015 The block SHALL have port busy  output  1  high in any state except IDLE.

Function
REQ-016 States SHALL be IDLE, CFG, ARMED, CAPTURE, DUMP.
REQ-017 In IDLE: rx byte 0x41 -> ARMED; 0x52 -> CFG; other bytes ignored.
REQ-018 CFG SHALL consume exactly 10 following rx bytes: bytes 1-5 -> rise_mask[7:0]..[39:32], bytes 6-10 -> fall_mask, LSB byte first; then IDLE; payload bytes are never decoded as commands.
REQ-019 Byte 0x53 in ARMED, CAPTURE or DUMP SHALL abort to IDLE next cycle, dropping tx_valid and mem_we; all other bytes in those states ignored.
REQ-020 probe SHALL be registered every cycle as probe_q; trigger = |((probe & ~probe_q & rise_mask) | (~probe & probe_q & fall_mask)).
REQ-021 If rise_mask and fall_mask are both zero, trigger SHALL be forced true on the first ARMED cycle.
REQ-022 In the trigger cycle the block SHALL write probe to address 0 (mem_we=1) and enter CAPTURE.
REQ-023 CAPTURE SHALL write one probe sample per cycle at addresses 1..DEPTH-1, then enter DUMP; exactly DEPTH writes total.
REQ-024 DUMP SHALL read addresses 0..DEPTH-1 in order, sending each sample as 5 bytes, bits [7:0] first.
REQ-025 A byte transfers only when tx_valid && tx_ready; tx_data SHALL stay stable while tx_valid is high and not accepted.
REQ-026 After the last byte of address DEPTH-1 is accepted the block SHALL return to IDLE; total DUMP bytes = 5*DEPTH.
REQ-027 Address counter SHALL be ADDR_W bits, with no wrap beyond DEPTH-1 in either CAPTURE or DUMP.
REQ-028 mem_we SHALL be 0 outside ARMED-trigger and CAPTURE cycles.
REQ-029 rise_mask and fall_mask SHALL persist across captures until rewritten by CFG or reset.

Reset
REQ-030 rst_n low SHALL force IDLE at the next clk edge from any state, including mid-CFG and mid-DUMP.
REQ-031 Reset values SHALL be: tx_data 0, tx_valid 0, mem_we 0, mem_addr 0, mem_wdata 0, armed 0, busy 0, rise_mask 0, fall_mask 0, CFG byte count 0, probe_q 0.

Configuration
REQ-032 Macro SCOPE_FALL_TRIG_EN defined: fall_mask SHALL be loaded and used per REQ-018/REQ-020.
REQ-033 Macro SCOPE_FALL_TRIG_EN undefined: CFG SHALL still consume 10 bytes, bytes 6-10 discarded, fall_mask constant 0.

Verification (ADDR_W=4 for bench)
REQ-034 Reset, send 0x41 with probe constant -> forced trigger, 16 writes of constant, 80 tx bytes, busy low afterwards.
REQ-035 Send 0x52, 00 00 00 01 00, 00x5; send 0x41; raise probe[24] at cycle 50 -> addr 0 holds first sample with bit 24 set, no writes before it.
REQ-036 With SCOPE_FALL_TRIG_EN: fall_mask byte 6 = 0x01, probe[0] 1->0 triggers; without macro same stimulus stays ARMED.
REQ-037 Hold tx_ready low 20 cycles during DUMP -> tx_data stable, no byte lost or duplicated.
REQ-038 Send 0x53 mid-DUMP -> IDLE next cycle, tx_valid 0; subsequent 0x41 re-arms normally.
REQ-039 Assert rst_n low mid-CFG after 4 payload bytes -> masks 0; next 0x41 decoded as ARM.

Source files
------------

// File: rtl/scope_cmd_ctrl.sv
// scope_cmd_ctrl: UART-commanded capture controller (configure, arm, capture 2**ADDR_W samples, dump as bytes).
// Optional macro SCOPE_FALL_TRIG_EN enables loading and use of the falling-edge trigger mask.
module scope_cmd_ctrl #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   input  logic [39:0]       probe,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [39:0]       mem_wdata,
   input  logic [39:0]       mem_rdata,
   output logic              armed,
   output logic              busy
);
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_CFG     = 3'd1;
   localparam logic [2:0] ST_ARMED   = 3'd2;
   localparam logic [2:0] ST_CAPTURE = 3'd3;
   localparam logic [2:0] ST_DUMP    = 3'd4;

   localparam logic [1:0] DS_WAIT = 2'd0;
   localparam logic [1:0] DS_LOAD = 2'd1;
   localparam logic [1:0] DS_SEND = 2'd2;

   localparam logic [7:0] CMD_ARM  = 8'h41;
   localparam logic [7:0] CMD_CFG  = 8'h52;
   localparam logic [7:0] CMD_STOP = 8'h53;

   localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
   localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

   logic [2:0]        state_r, state_nxt_s;
   logic [1:0]        dstep_r;
   logic [2:0]        byte_idx_r;
   logic [3:0]        cfg_cnt_r;
   logic [39:0]       rise_mask_r, fall_mask_s, probe_q_r;
   logic [31:0]       rest_r;
   logic [7:0]        tx_data_r;
   logic              tx_valid_r, mem_we_r, armed_r, busy_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [39:0]       mem_wdata_r;
   logic              cmd_stop_s, trigger_s, tx_fire_s, dump_last_s;

`ifdef SCOPE_FALL_TRIG_EN
   logic [39:0] fall_mask_r;
   // Fall mask collects CFG payload bytes 6-10, least significant byte first
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fall_mask_r <= 40'd0;
      end else if (state_r == ST_CFG && rx_valid && cfg_cnt_r >= 4'd5) begin
         fall_mask_r <= {rx_data, fall_mask_r[39:8]};
      end
   end
   assign fall_mask_s = fall_mask_r;
`else
   assign fall_mask_s = 40'd0;
`endif

   assign cmd_stop_s  = rx_valid && (rx_data == CMD_STOP);
   // With no mask bits set the first ARMED cycle always fires
   assign trigger_s   = ((rise_mask_r | fall_mask_s) == 40'd0) ||
                        (|((probe & ~probe_q_r & rise_mask_r) | (~probe & probe_q_r & fall_mask_s)));
   assign tx_fire_s   = tx_valid_r && tx_ready;
   assign dump_last_s = (dstep_r == DS_SEND) && tx_fire_s && (byte_idx_r == 3'd4) && (mem_addr_r == ADDR_LAST);

   // Next-state decode for the command/capture FSM
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (rx_valid && rx_data == CMD_ARM) begin
               state_nxt_s = ST_ARMED;
            end else if (rx_valid && rx_data == CMD_CFG) begin
               state_nxt_s = ST_CFG;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_CFG: begin
            if (rx_valid && cfg_cnt_r == 4'd9) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_CFG;
            end
         end
         ST_ARMED: begin
            if (cmd_stop_s) begin
               state_nxt_s = ST_IDLE;
            end else if (trigger_s) begin
               state_nxt_s = ST_CAPTURE;
            end else begin
               state_nxt_s = ST_ARMED;
            end
         end
         ST_CAPTURE: begin
            if (cmd_stop_s) begin
               state_nxt_s = ST_IDLE;
            end else if (mem_addr_r == ADDR_LAST) begin
               state_nxt_s = ST_DUMP;
            end else begin
               state_nxt_s = ST_CAPTURE;
            end
         end
         ST_DUMP: begin
            if (cmd_stop_s || dump_last_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_DUMP;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State, configuration, capture-write and dump-serialiser registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         armed_r     <= 1'b0;
         busy_r      <= 1'b0;
         cfg_cnt_r   <= 4'd0;
         rise_mask_r <= 40'd0;
         probe_q_r   <= 40'd0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= ADDR_ZERO;
         mem_wdata_r <= 40'd0;
         tx_data_r   <= 8'd0;
         tx_valid_r  <= 1'b0;
         dstep_r     <= DS_WAIT;
         byte_idx_r  <= 3'd0;
         rest_r      <= 32'd0;
      end else begin
         state_r   <= state_nxt_s;
         armed_r   <= (state_nxt_s == ST_ARMED);
         busy_r    <= (state_nxt_s != ST_IDLE);
         probe_q_r <= probe;
         mem_we_r  <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               mem_addr_r <= ADDR_ZERO;
               tx_valid_r <= 1'b0;
               cfg_cnt_r  <= 4'd0;
            end
            ST_CFG: begin
               if (rx_valid) begin
                  if (cfg_cnt_r < 4'd5) begin
                     rise_mask_r <= {rx_data, rise_mask_r[39:8]};
                  end
                  cfg_cnt_r <= (cfg_cnt_r == 4'd9) ? 4'd0 : cfg_cnt_r + 4'd1;
               end
            end
            ST_ARMED: begin
               if (!cmd_stop_s && trigger_s) begin
                  mem_we_r    <= 1'b1;
                  mem_addr_r  <= ADDR_ZERO;
                  mem_wdata_r <= probe;
               end
            end
            ST_CAPTURE: begin
               if (!cmd_stop_s) begin
                  if (mem_addr_r == ADDR_LAST) begin
                     mem_addr_r <= ADDR_ZERO;
                     dstep_r    <= DS_WAIT;
                  end else begin
                     mem_we_r    <= 1'b1;
                     mem_addr_r  <= mem_addr_r + ADDR_ONE;
                     mem_wdata_r <= probe;
                  end
               end
            end
            ST_DUMP: begin
               if (cmd_stop_s) begin
                  tx_valid_r <= 1'b0;
               end else begin
                  // WAIT covers the one-cycle read latency, LOAD latches the sample
                  case (dstep_r)
                     DS_WAIT: dstep_r <= DS_LOAD;
                     DS_LOAD: begin
                        tx_data_r  <= mem_rdata[7:0];
                        rest_r     <= mem_rdata[39:8];
                        tx_valid_r <= 1'b1;
                        byte_idx_r <= 3'd0;
                        dstep_r    <= DS_SEND;
                     end
                     DS_SEND: begin
                        if (tx_fire_s) begin
                           if (byte_idx_r == 3'd4) begin
                              tx_valid_r <= 1'b0;
                              dstep_r    <= DS_WAIT;
                              if (mem_addr_r != ADDR_LAST) begin
                                 mem_addr_r <= mem_addr_r + ADDR_ONE;
                              end
                           end else begin
                              tx_data_r  <= rest_r[7:0];
                              rest_r     <= {8'd0, rest_r[31:8]};
                              byte_idx_r <= byte_idx_r + 3'd1;
                           end
                        end
                     end
                     default: dstep_r <= DS_WAIT;
                  endcase
               end
            end
            default: mem_we_r <= 1'b0;
         endcase
      end
   end

   assign tx_data   = tx_data_r;
   assign tx_valid  = tx_valid_r;
   assign mem_we    = mem_we_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;
   assign armed     = armed_r;
   assign busy      = busy_r;
endmodule

// File: tb/tb_scope_cmd_ctrl.sv
// Self-checking bench for scope_cmd_ctrl (ADDR_W=4): random probe/tx_ready stimulus checked
// against a trigger/capture/dump model computed from the logged probe history.
module tb_scope_cmd_ctrl;
   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int LOGN  = 65536;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [7:0]    rx_data = 8'd0;
   logic          rx_valid = 1'b0;
   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          tx_ready = 1'b0;
   logic [39:0]   probe = 40'd0;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [39:0]   mem_wdata;
   logic [39:0]   mem_rdata = 40'd0;
   logic          armed;
   logic          busy;

   int tests = 0;
   int failed = 0;

   scope_cmd_ctrl #(.ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .probe(probe),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .armed(armed), .busy(busy)
   );

   always #5 clk = ~clk;

   // capture buffer with one-cycle read latency
   logic [39:0] mem [0:DEPTH-1];
   always @(posedge clk) begin
      if (mem_we === 1'b1) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   // probe and tx_ready stimulus
   logic [39:0] rand_mask = 40'hFF_FFFF_FFFF;
   logic [39:0] probe_fixed = 40'd0;
   logic        hold_ready = 1'b0;
   logic [63:0] rnd;
   always @(negedge clk) begin
      rnd = {$urandom, $urandom};
      probe = (rnd[39:0] & rand_mask) | (probe_fixed & ~rand_mask);
      tx_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
   end

   // monitor: probe history per edge, observed writes and transferred bytes
   int            cyc = 0;
   logic [39:0]   plog [0:LOGN-1];
   logic [AW-1:0] wa_q[$];
   logic [39:0]   wd_q[$];
   logic [7:0]    tx_q[$];
   int            stab_err = 0;
   logic          stall_prev = 1'b0;
   logic [7:0]    stall_data = 8'd0;
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (cyc < LOGN) plog[cyc] = probe;
      if (mem_we === 1'b1) begin
         wa_q.push_back(mem_addr);
         wd_q.push_back(mem_wdata);
      end
      if (tx_valid === 1'b1 && tx_ready === 1'b1) tx_q.push_back(tx_data);
      if (stall_prev && busy === 1'b1 && (tx_valid !== 1'b1 || tx_data !== stall_data)) stab_err++;
      stall_prev = (tx_valid === 1'b1) && (tx_ready === 1'b0);
      stall_data = tx_data;
   end

   // reference model state
   logic [39:0]   rise_m = 40'd0;
   logic [39:0]   fall_m = 40'd0;
   logic [AW-1:0] exp_wa[$];
   logic [39:0]   exp_wd[$];
   logic [7:0]    exp_tx[$];

   task automatic build_model(input int n, output int t);
      logic [39:0] cur, prv;
      t = -1;
      exp_wa.delete(); exp_wd.delete(); exp_tx.delete();
      for (int c = n + 1; c < cyc && t < 0; c++) begin
         cur = plog[c];
         prv = plog[c-1];
         if ((rise_m == 40'd0 && fall_m == 40'd0) ||
             (((cur & ~prv & rise_m) | (~cur & prv & fall_m)) != 40'd0)) t = c;
      end
      if (t >= 0) begin
         for (int k = 0; k < DEPTH; k++) begin
            exp_wa.push_back(AW'(k));
            exp_wd.push_back(plog[t+k]);
            for (int j = 0; j < 5; j++) exp_tx.push_back(plog[t+k][8*j +: 8]);
         end
      end
   endtask

   task automatic send_byte(input logic [7:0] b, output int n);
      @(negedge clk);
      rx_data = b; rx_valid = 1'b1; n = cyc + 1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_cfg(input logic [39:0] rise, input logic [39:0] fall);
      int n;
      send_byte(8'h52, n);
      for (int i = 0; i < 5; i++) send_byte(rise[8*i +: 8], n);
      for (int i = 0; i < 5; i++) send_byte(fall[8*i +: 8], n);
      rise_m = rise;
`ifdef SCOPE_FALL_TRIG_EN
      fall_m = fall;
`else
      fall_m = 40'd0;
`endif
   endtask

   task automatic clear_q();
      wa_q.delete(); wd_q.delete(); tx_q.delete();
   endtask

   task automatic wait_idle(input string name);
      int g = 0;
      while (busy !== 1'b0 && g < 3000) begin
         @(negedge clk);
         g++;
      end
      tests++;
      if (busy !== 1'b0) begin
         failed++;
         $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", name, busy, g);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      tests++;
      if (tx_data !== 8'd0 || tx_valid !== 1'b0) begin
         failed++; $display("FAIL reset_tx: tx_data=%h tx_valid=%b, required 00/0", tx_data, tx_valid);
      end
      tests++;
      if (mem_we !== 1'b0 || mem_addr !== 4'd0 || mem_wdata !== 40'd0) begin
         failed++; $display("FAIL reset_mem: we=%b addr=%h wdata=%h, required 0/0/0", mem_we, mem_addr, mem_wdata);
      end
      tests++;
      if (armed !== 1'b0 || busy !== 1'b0) begin
         failed++; $display("FAIL reset_status: armed=%b busy=%b, required 0/0", armed, busy);
      end
      rst_n = 1'b1;
      rise_m = 40'd0; fall_m = 40'd0;
      @(negedge clk);
   endtask

   task automatic test_forced_trigger();
      int n, t, mm;
      rand_mask = 40'd0;
      rnd = {$urandom, $urandom};
      probe_fixed = rnd[39:0];
      repeat (3) @(negedge clk);
      clear_q();
      send_byte(8'h41, n);
      tests++;
      if (armed !== 1'b1) begin failed++; $display("FAIL forced_armed: armed=%b, required 1", armed); end
      wait_idle("forced");
      build_model(n, t);
      mm = 0;
      foreach (exp_wd[i]) if (i >= wd_q.size() || wd_q[i] !== exp_wd[i] || wa_q[i] !== exp_wa[i] || wd_q[i] !== probe_fixed) mm++;
      tests++;
      if (t < 0 || wd_q.size() != DEPTH || mm != 0) begin
         failed++; $display("FAIL forced_writes: %0d writes %0d bad, required %0d writes 0 bad", wd_q.size(), mm, DEPTH);
      end
      mm = 0;
      foreach (exp_tx[i]) if (i >= tx_q.size() || tx_q[i] !== exp_tx[i]) mm++;
      tests++;
      if (tx_q.size() != 5*DEPTH || mm != 0) begin
         failed++; $display("FAIL forced_tx: %0d bytes %0d bad, required %0d bytes 0 bad", tx_q.size(), mm, 5*DEPTH);
      end
   endtask

   task automatic test_rise_trigger();
      int n, t, mm;
      rand_mask = ~40'h00_0100_0000;
      probe_fixed = 40'd0;
      send_cfg(40'h00_0100_0000, 40'd0);
      clear_q();
      send_byte(8'h41, n);
      repeat (49) @(negedge clk);
      tests++;
      if (armed !== 1'b1 || wd_q.size() != 0) begin
         failed++; $display("FAIL rise_pre: armed=%b writes=%0d, required 1/0", armed, wd_q.size());
      end
      probe_fixed = 40'h00_0100_0000;
      wait_idle("rise");
      build_model(n, t);
      tests++;
      if (wd_q.size() == 0 || wd_q[0][24] !== 1'b1) begin
         failed++; $display("FAIL rise_first: writes=%0d first bit24 not set, required set", wd_q.size());
      end
      mm = 0;
      foreach (exp_wd[i]) if (i >= wd_q.size() || wd_q[i] !== exp_wd[i] || wa_q[i] !== exp_wa[i]) mm++;
      tests++;
      if (t < 0 || wd_q.size() != DEPTH || mm != 0) begin
         failed++; $display("FAIL rise_writes: %0d writes %0d bad, required %0d writes 0 bad", wd_q.size(), mm, DEPTH);
      end
      mm = 0;
      foreach (exp_tx[i]) if (i >= tx_q.size() || tx_q[i] !== exp_tx[i]) mm++;
      tests++;
      if (tx_q.size() != 5*DEPTH || mm != 0) begin
         failed++; $display("FAIL rise_tx: %0d bytes %0d bad, required %0d bytes 0 bad", tx_q.size(), mm, 5*DEPTH);
      end
   endtask

   task automatic test_fall_trigger();
      int n, t, mm;
      rand_mask = ~40'h00_0100_0001;
      probe_fixed = 40'd1;
      send_cfg(40'h00_0100_0000, 40'd1);
      clear_q();
      send_byte(8'h41, n);
      repeat (20) @(negedge clk);
      tests++;
      if (armed !== 1'b1 || wd_q.size() != 0) begin
         failed++; $display("FAIL fall_pre: armed=%b writes=%0d, required 1/0", armed, wd_q.size());
      end
      probe_fixed = 40'd0;
`ifdef SCOPE_FALL_TRIG_EN
      wait_idle("fall");
      build_model(n, t);
      mm = 0;
      foreach (exp_wd[i]) if (i >= wd_q.size() || wd_q[i] !== exp_wd[i] || wa_q[i] !== exp_wa[i]) mm++;
      tests++;
      if (t < 0 || wd_q.size() != DEPTH || mm != 0) begin
         failed++; $display("FAIL fall_writes: %0d writes %0d bad, required %0d writes 0 bad", wd_q.size(), mm, DEPTH);
      end
      mm = 0;
      foreach (exp_tx[i]) if (i >= tx_q.size() || tx_q[i] !== exp_tx[i]) mm++;
      tests++;
      if (tx_q.size() != 5*DEPTH || mm != 0) begin
         failed++; $display("FAIL fall_tx: %0d bytes %0d bad, required %0d bytes 0 bad", tx_q.size(), mm, 5*DEPTH);
      end
`else
      repeat (40) @(negedge clk);
      tests++;
      if (armed !== 1'b1 || wd_q.size() != 0) begin
         failed++; $display("FAIL fall_disabled: armed=%b writes=%0d, required 1/0", armed, wd_q.size());
      end
      send_byte(8'h53, n);
      tests++;
      if (busy !== 1'b0) begin failed++; $display("FAIL fall_stop: busy=%b, required 0", busy); end
`endif
   endtask

   task automatic test_backpressure();
      int n, t, mm, g, bad;
      logic [7:0] held;
      rand_mask = 40'hFF_FFFF_FFFF;
      send_cfg(40'd0, 40'd0);
      clear_q();
      send_byte(8'h41, n);
      g = 0;
      while (tx_valid !== 1'b1 && g < 200) begin @(negedge clk); g++; end
      hold_ready = 1'b1;
      repeat (4) @(negedge clk);
      held = tx_data;
      tests++;
      if (tx_valid !== 1'b1) begin failed++; $display("FAIL bp_valid: tx_valid=%b, required 1", tx_valid); end
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (tx_valid !== 1'b1 || tx_data !== held) bad++;
      end
      tests++;
      if (bad != 0) begin failed++; $display("FAIL bp_stable: %0d unstable cycles (held %h), required 0", bad, held); end
      hold_ready = 1'b0;
      wait_idle("bp");
      build_model(n, t);
      mm = 0;
      foreach (exp_tx[i]) if (i >= tx_q.size() || tx_q[i] !== exp_tx[i]) mm++;
      tests++;
      if (t < 0 || tx_q.size() != 5*DEPTH || mm != 0) begin
         failed++; $display("FAIL bp_tx: %0d bytes %0d bad, required %0d bytes 0 bad", tx_q.size(), mm, 5*DEPTH);
      end
      tests++;
      if (stab_err != 0) begin failed++; $display("FAIL tx_hold: %0d stalled-byte changes, required 0", stab_err); end
   endtask

   task automatic test_abort();
      int n, t, mm, g;
      clear_q();
      send_byte(8'h41, n);
      g = 0;
      while (tx_q.size() < 7 && g < 500) begin @(negedge clk); g++; end
      send_byte(8'h53, n);
      tests++;
      if (busy !== 1'b0 || tx_valid !== 1'b0 || mem_we !== 1'b0 || tx_q.size() < 7) begin
         failed++; $display("FAIL abort_idle: busy=%b tx_valid=%b we=%b bytes=%0d, required 0/0/0/>=7", busy, tx_valid, mem_we, tx_q.size());
      end
      repeat (2) @(negedge clk);
      clear_q();
      send_byte(8'h41, n);
      tests++;
      if (armed !== 1'b1) begin failed++; $display("FAIL abort_rearm: armed=%b, required 1", armed); end
      wait_idle("rearm");
      build_model(n, t);
      mm = 0;
      foreach (exp_tx[i]) if (i >= tx_q.size() || tx_q[i] !== exp_tx[i]) mm++;
      tests++;
      if (t < 0 || tx_q.size() != 5*DEPTH || wd_q.size() != DEPTH || mm != 0) begin
         failed++; $display("FAIL rearm_tx: %0d bytes %0d bad %0d writes, required %0d bytes 0 bad %0d writes", tx_q.size(), mm, wd_q.size(), 5*DEPTH, DEPTH);
      end
   endtask

   task automatic test_reset_mid_cfg();
      int n, t, mm;
      logic [39:0] r;
      rand_mask = 40'd0;
      probe_fixed = 40'h5A_A5C3_3C0F;
      rnd = {$urandom, $urandom};
      r = rnd[39:0] | 40'h00_0000_0080;
      send_cfg(r, r);
      send_byte(8'h52, n);
      for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 255)), n);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      rise_m = 40'd0; fall_m = 40'd0;
      clear_q();
      send_byte(8'h41, n);
      tests++;
      if (armed !== 1'b1) begin failed++; $display("FAIL rstcfg_arm: armed=%b, required 1", armed); end
      wait_idle("rstcfg");
      build_model(n, t);
      mm = 0;
      foreach (exp_wd[i]) if (i >= wd_q.size() || wd_q[i] !== exp_wd[i] || wa_q[i] !== exp_wa[i]) mm++;
      tests++;
      if (t < 0 || wd_q.size() != DEPTH || mm != 0) begin
         failed++; $display("FAIL rstcfg_writes: %0d writes %0d bad, required %0d writes 0 bad", wd_q.size(), mm, DEPTH);
      end
   endtask

   initial begin
      test_reset();
      test_forced_trigger();
      test_rise_trigger();
      test_fall_trigger();
      test_backpressure();
      test_abort();
      test_reset_mid_cfg();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
      $fatal(1, "watchdog");
   end
endmodule
